// File: rtl/mor1kx_cfgrs_pkg.sv
// Shared constants and FSM state type for the group-0 configuration register responder.
// The MOR1KX_CFGRS_ERRCNT_EN build option adds the violation counter at ERRCNT_IDX.
package mor1kx_cfgrs_pkg;

    localparam int VR_IDX       = 0;
    localparam int UPR_IDX      = 1;
    localparam int CPUCFGR_IDX  = 2;
    localparam int DMMUCFGR_IDX = 3;
    localparam int IMMUCFGR_IDX = 4;
    localparam int DCCFGR_IDX   = 5;
    localparam int ICCFGR_IDX   = 6;
    localparam int DCFGR_IDX    = 7;
    localparam int PCCFGR_IDX   = 8;
    localparam int VR2_IDX      = 9;
    localparam int AVR_IDX      = 10;
    localparam int ERRCNT_IDX   = 13;
    localparam int FPCSR_IDX    = 20;

    localparam logic [4:0] GROUP_SYS = 5'd0;

    // One-hot select layout: bits 0..10 follow the index, then FPCSR, then the counter.
    localparam int SEL_W      = 13;
    localparam int SEL_FPCSR  = 11;
    localparam int SEL_ERRCNT = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } cfgrs_state_t;

endpackage

// File: rtl/mor1kx_cfgrs_spr_dec.sv
// Combinational group-0 address decode: hit flag plus one-hot register select.
// Index 13 decodes only when MOR1KX_CFGRS_ERRCNT_EN is defined.
module mor1kx_cfgrs_spr_dec
    import mor1kx_cfgrs_pkg::*;
#(
    parameter int SPR_ADDR_WIDTH = 16
) (
    input  logic [SPR_ADDR_WIDTH-1:0] spr_addr,
    output logic                      hit,
    output logic [SEL_W-1:0]          sel
);

    logic [10:0] idx;
    logic        grp_ok;

    assign idx    = spr_addr[10:0];
    assign grp_ok = (spr_addr[15:11] == GROUP_SYS);

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i <= AVR_IDX; i++) begin
            sel[i] = grp_ok && (idx == 11'(i));
        end
        sel[SEL_FPCSR] = grp_ok && (idx == 11'(FPCSR_IDX));
`ifdef MOR1KX_CFGRS_ERRCNT_EN
        sel[SEL_ERRCNT] = grp_ok && (idx == 11'(ERRCNT_IDX));
`else
        sel[SEL_ERRCNT] = 1'b0;
`endif
        hit = |sel;
    end

endmodule

// File: rtl/mor1kx_cfgrs_spr_resp.sv
// SPR-bus responder for the read-only group-0 configuration registers.
// Define MOR1KX_CFGRS_ERRCNT_EN to add the saturating write-violation counter at index 13.
module mor1kx_cfgrs_spr_resp
    import mor1kx_cfgrs_pkg::*;
#(
    parameter int WAIT_STATES    = 0,
    parameter int SPR_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SPR_ADDR_WIDTH-1:0] spr_bus_addr_i,
    input  logic                      spr_bus_we_i,
    input  logic                      spr_bus_stb_i,
    input  logic [31:0]               spr_bus_dat_i,
    output logic [31:0]               spr_bus_dat_o,
    output logic                      spr_bus_ack_o,
    output logic                      ro_wr_err_o,
    input  logic [31:0]               cfg_vr_i,
    input  logic [31:0]               cfg_upr_i,
    input  logic [31:0]               cfg_cpucfgr_i,
    input  logic [31:0]               cfg_dmmucfgr_i,
    input  logic [31:0]               cfg_immucfgr_i,
    input  logic [31:0]               cfg_dccfgr_i,
    input  logic [31:0]               cfg_iccfgr_i,
    input  logic [31:0]               cfg_dcfgr_i,
    input  logic [31:0]               cfg_pccfgr_i,
    input  logic [31:0]               cfg_vr2_i,
    input  logic [31:0]               cfg_avr_i,
    input  logic [31:0]               cfg_fpcsr_i
);

    // Ack is registered, so WAIT_STATES=0 goes straight IDLE->ACK and a non-zero
    // setting loads WAIT_STATES-1; either way ack lands in cycle N+1+WAIT_STATES.
    localparam logic [1:0] WAIT_LOAD = 2'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    cfgrs_state_t     state_q, state_d;
    logic [1:0]       wait_q, wait_d;
    logic [SEL_W-1:0] sel_live, sel_q, sel_mux;
    logic             hit_live, we_q, we_mux, enter_ack, wr_err;
    logic [31:0]      rd_word;
    logic             ack_q, err_q;
    logic [31:0]      dat_q;
    logic             unused_wdat;
`ifdef MOR1KX_CFGRS_ERRCNT_EN
    logic [7:0]       errcnt_q;
`endif

    assign unused_wdat = ^spr_bus_dat_i;

    mor1kx_cfgrs_spr_dec #(.SPR_ADDR_WIDTH(SPR_ADDR_WIDTH)) u_dec (
        .spr_addr (spr_bus_addr_i),
        .hit      (hit_live),
        .sel      (sel_live)
    );

    assign sel_mux = (state_q == ST_IDLE) ? sel_live     : sel_q;
    assign we_mux  = (state_q == ST_IDLE) ? spr_bus_we_i : we_q;
    assign wr_err  = enter_ack && we_mux && !sel_mux[SEL_ERRCNT];

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        enter_ack = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (spr_bus_stb_i && hit_live) begin
                    if (WAIT_STATES == 0) begin
                        state_d   = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wait_d  = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!spr_bus_stb_i) begin
                    state_d = ST_IDLE;
                end else if (wait_q == 2'd0) begin
                    state_d   = ST_ACK;
                    enter_ack = 1'b1;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            ST_ACK:  state_d = ST_HOLD;
            ST_HOLD: if (!spr_bus_stb_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        if (sel_mux[VR_IDX])       rd_word = rd_word | cfg_vr_i;
        if (sel_mux[UPR_IDX])      rd_word = rd_word | cfg_upr_i;
        if (sel_mux[CPUCFGR_IDX])  rd_word = rd_word | cfg_cpucfgr_i;
        if (sel_mux[DMMUCFGR_IDX]) rd_word = rd_word | cfg_dmmucfgr_i;
        if (sel_mux[IMMUCFGR_IDX]) rd_word = rd_word | cfg_immucfgr_i;
        if (sel_mux[DCCFGR_IDX])   rd_word = rd_word | cfg_dccfgr_i;
        if (sel_mux[ICCFGR_IDX])   rd_word = rd_word | cfg_iccfgr_i;
        if (sel_mux[DCFGR_IDX])    rd_word = rd_word | cfg_dcfgr_i;
        if (sel_mux[PCCFGR_IDX])   rd_word = rd_word | cfg_pccfgr_i;
        if (sel_mux[VR2_IDX])      rd_word = rd_word | cfg_vr2_i;
        if (sel_mux[AVR_IDX])      rd_word = rd_word | cfg_avr_i;
        if (sel_mux[SEL_FPCSR])    rd_word = rd_word | cfg_fpcsr_i;
`ifdef MOR1KX_CFGRS_ERRCNT_EN
        if (sel_mux[SEL_ERRCNT])   rd_word = rd_word | {24'd0, errcnt_q};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == ST_IDLE) begin
                sel_q <= sel_live;
                we_q  <= spr_bus_we_i;
            end
            ack_q <= enter_ack;
            err_q <= wr_err;
            dat_q <= (enter_ack && !we_mux) ? rd_word : '0;
        end
    end

`ifdef MOR1KX_CFGRS_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errcnt_q <= '0;
        end else if (enter_ack && we_mux && sel_mux[SEL_ERRCNT]) begin
            errcnt_q <= '0;
        end else if (wr_err && (errcnt_q != 8'hff)) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end
`endif

    assign spr_bus_ack_o = ack_q;
    assign spr_bus_dat_o = dat_q;
    assign ro_wr_err_o   = err_q;

endmodule

// File: tb/tb_mor1kx_cfgrs_spr_resp.sv
// Self-checking bench: three responders (WAIT_STATES 0, 2, 3) driven from a vector table
// plus hand sequences for abort, reset-in-WAIT and the optional MOR1KX_CFGRS_ERRCNT_EN counter.
module tb_mor1kx_cfgrs_spr_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic        we = 1'b0;
    logic [31:0] wdat = '0;
    logic [2:0]  stb = '0;
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [31:0] dat [3];
    logic [31:0] cfg [12];

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    typedef struct {
        int          d;
        logic [15:0] a;
        logic        w;
        logic [31:0] wd;
        logic        hit;
        logic [31:0] dat;
        logic        err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mor1kx_cfgrs_spr_resp #(
            .WAIT_STATES    ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
            .SPR_ADDR_WIDTH (16)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .spr_bus_addr_i (addr),
            .spr_bus_we_i   (we),
            .spr_bus_stb_i  (stb[g]),
            .spr_bus_dat_i  (wdat),
            .spr_bus_dat_o  (dat[g]),
            .spr_bus_ack_o  (ack[g]),
            .ro_wr_err_o    (err[g]),
            .cfg_vr_i       (cfg[0]),
            .cfg_upr_i      (cfg[1]),
            .cfg_cpucfgr_i  (cfg[2]),
            .cfg_dmmucfgr_i (cfg[3]),
            .cfg_immucfgr_i (cfg[4]),
            .cfg_dccfgr_i   (cfg[5]),
            .cfg_iccfgr_i   (cfg[6]),
            .cfg_dcfgr_i    (cfg[7]),
            .cfg_pccfgr_i   (cfg[8]),
            .cfg_vr2_i      (cfg[9]),
            .cfg_avr_i      (cfg[10]),
            .cfg_fpcsr_i    (cfg[11])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic add(input int d, input logic [15:0] a, input logic w, input logic [31:0] wd,
                       input logic hit, input logic [31:0] edat, input logic eerr);
        vec_t v;
        v.d = d; v.a = a; v.w = w; v.wd = wd; v.hit = hit; v.dat = edat; v.err = eerr;
        vecs.push_back(v);
    endtask

    // Holds the strobe for 'hold' cycles, then watches two idle cycles; scramble
    // changes addr/we after the first cycle to prove the request was latched.
    task automatic run_txn(input int d, input logic [15:0] a, input logic w, input logic [31:0] wd,
                           input logic hit, input logic [31:0] edat, input logic eerr,
                           input int hold, input logic scramble);
        int   acks = 0;
        int   lat = 0;
        exp_t e;
        if (hit) begin
            e.dat = edat;
            e.err = eerr;
            sb.push_back(e);
        end
        addr = a; we = w; wdat = wd; stb[d] = 1'b1;
        for (int c = 1; c <= hold + 2; c++) begin
            @(negedge clk);
            if (ack[d]) begin
                acks++;
                if (lat == 0) lat = c;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("dat d%0d a%h", d, a), dat[d], e.dat);
                    chk($sformatf("err d%0d a%h", d, a), {31'd0, err[d]}, {31'd0, e.err});
                end
            end else begin
                chk($sformatf("noack_dat d%0d a%h", d, a), dat[d], 32'd0);
                chk($sformatf("noack_err d%0d a%h", d, a), {31'd0, err[d]}, 32'd0);
            end
            if (scramble && c == 1) begin
                addr = 16'h0011;
                we = ~w;
            end
            if (c == hold) stb[d] = 1'b0;
        end
        chk($sformatf("ack_count d%0d a%h", d, a), acks, hit ? 32'd1 : 32'd0);
        if (hit) chk($sformatf("latency d%0d a%h", d, a), lat, 1 + ws_of(d));
    endtask

    initial begin
        for (int k = 0; k < 12; k++) cfg[k] = 32'hc0de_0000 | (k * 32'h0000_0101);
        cfg[2] = 32'h0000_0620;

        // reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ack d%0d", d), {31'd0, ack[d]}, 32'd0);
            chk($sformatf("rst_err d%0d", d), {31'd0, err[d]}, 32'd0);
            chk($sformatf("rst_dat d%0d", d), dat[d], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k <= 10; k++) add(0, 16'(k), 1'b0, 32'd0, 1'b1, cfg[k], 1'b0);
        add(0, 16'h0014, 1'b0, 32'd0, 1'b1, cfg[11], 1'b0);
        add(0, 16'h0001, 1'b1, 32'hdead_beef, 1'b1, 32'd0, 1'b1);
        add(0, 16'h0001, 1'b0, 32'd0, 1'b1, cfg[1], 1'b0);
        add(1, 16'h0009, 1'b0, 32'd0, 1'b1, cfg[9], 1'b0);
        add(1, 16'h0014, 1'b1, 32'h1234_5678, 1'b1, 32'd0, 1'b1);
        add(2, 16'h0003, 1'b0, 32'd0, 1'b1, cfg[3], 1'b0);
        add(0, 16'h0011, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        add(0, 16'h0800, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        add(0, 16'h000b, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        add(0, 16'h0015, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0);
        add(0, 16'h0801, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        add(2, 16'h0011, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
`ifndef MOR1KX_CFGRS_ERRCNT_EN
        add(0, 16'h000d, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        add(0, 16'h000d, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i].d, vecs[i].a, vecs[i].w, vecs[i].wd, vecs[i].hit,
                    vecs[i].dat, vecs[i].err, (vecs[i].hit ? 6 : 10), 1'b0);
        end

        // latched address/we survive bus changes mid-transaction
        run_txn(1, 16'h0005, 1'b0, 32'd0, 1'b1, cfg[5], 1'b0, 6, 1'b1);
        run_txn(2, 16'h0002, 1'b1, 32'h0bad_f00d, 1'b1, 32'd0, 1'b1, 6, 1'b1);

        // abort in WAIT
        addr = 16'h000a; we = 1'b0; stb[2] = 1'b1;
        @(negedge clk);
        stb[2] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("abort_ack", {31'd0, ack[2]}, 32'd0);
            chk("abort_err", {31'd0, err[2]}, 32'd0);
        end

        // reset asserted while in WAIT
        stb[2] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstwait_ack", {31'd0, ack[2]}, 32'd0);
        chk("rstwait_err", {31'd0, err[2]}, 32'd0);
        chk("rstwait_dat", dat[2], 32'd0);
        @(negedge clk);
        stb[2] = 1'b0;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("postrst_ack", {31'd0, ack[2]}, 32'd0);
        end
        run_txn(2, 16'h000a, 1'b0, 32'd0, 1'b1, cfg[10], 1'b0, 6, 1'b0);

`ifdef MOR1KX_CFGRS_ERRCNT_EN
        // counter was cleared by the reset pulse above
        for (int n = 0; n < 5; n++) run_txn(0, 16'h0000, 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 3, 1'b0);
        run_txn(0, 16'h000d, 1'b0, 32'd0, 1'b1, 32'd5, 1'b0, 3, 1'b0);
        for (int n = 0; n < 295; n++) run_txn(0, 16'h0000, 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 3, 1'b0);
        run_txn(0, 16'h000d, 1'b0, 32'd0, 1'b1, 32'h0000_00ff, 1'b0, 3, 1'b0);
        run_txn(0, 16'h000d, 1'b1, 32'hffff_ffff, 1'b1, 32'd0, 1'b0, 3, 1'b0);
        run_txn(0, 16'h000d, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 3, 1'b0);
        run_txn(0, 16'h0004, 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 3, 1'b0);
        run_txn(0, 16'h000d, 1'b0, 32'd0, 1'b1, 32'd1, 1'b0, 3, 1'b0);
`endif

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
